// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage, the control FSM and the decoder.
// Optional ack timeout is enabled by defining CPU_FETCH_TIMEOUT_EN.
package cpu_fetch_pkg;

  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 16;

  typedef enum logic [1:0] {
    FS_IDLE = 2'b00,
    FS_REQ  = 2'b01,
    FS_DONE = 2'b10
  } fetch_state_e;

  // A zero word decodes as NOP; loaded into ir when a fetch is abandoned.
  localparam logic [FETCH_INSTR_W-1:0] INSTR_NOP = '0;

endpackage

// File: rtl/cpu_fetch_unit_timeout.sv
// Cycle counter for an outstanding fetch: clears on request entry, counts idle request cycles,
// and flags expiry on the TIMEOUT-th cycle. Used only when CPU_FETCH_TIMEOUT_EN is defined.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry is seen during the TIMEOUT-th waiting cycle, so the abort lands on that edge.
  assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                     cnt_d = '0;
    else if (enable_i && !expired_o) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: one outstanding req/ack read per fetch_start, with branch redirect
// and sleep quiescing. Define CPU_FETCH_TIMEOUT_EN to abort fetches whose ack never arrives.
module cpu_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int          ADDR_W   = FETCH_ADDR_W,
  parameter int          INSTR_W  = FETCH_INSTR_W,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_start,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               sleep_req,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_done,
  output logic               busy,
  output logic               fetch_err
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               mem_req_q, mem_req_d;
  logic               ir_valid_q, ir_valid_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;

  // A redirect raised in the same cycle as the ack takes precedence over an older pending one.
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  assign redirect      = pend_q | branch_valid;
  assign redirect_addr = branch_valid ? branch_target : pend_addr_q;

`ifdef CPU_FETCH_TIMEOUT_EN
  logic err_q, err_d;
  logic tmo_clear, tmo_enable, tmo_expired;

  assign tmo_clear  = (state_q != FS_REQ) || (mem_ack && redirect);
  assign tmo_enable = (state_q == FS_REQ) && !mem_ack;

  fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .expired_o (tmo_expired)
  );

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    ir_d        = ir_q;
    mem_req_d   = mem_req_q;
    ir_valid_d  = ir_valid_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
`ifdef CPU_FETCH_TIMEOUT_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      FS_IDLE: begin
        if (branch_valid) pc_d = branch_target;
        if (fetch_start && !sleep_req) begin
          state_d    = FS_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = branch_valid ? branch_target : pc_q;
          ir_valid_d = 1'b0;
`ifdef CPU_FETCH_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end
      end
      FS_REQ: begin
        if (mem_ack) begin
          if (redirect) begin
            // Stale word from the old path is dropped; reissue at the target.
            pc_d       = redirect_addr;
            mem_addr_d = redirect_addr;
            pend_d     = 1'b0;
          end else begin
            ir_d       = mem_rdata;
            pc_d       = pc_q + ADDR_W'(1);
            mem_req_d  = 1'b0;
            ir_valid_d = 1'b1;
            state_d    = FS_DONE;
          end
        end else begin
          if (branch_valid) begin
            pend_d      = 1'b1;
            pend_addr_d = branch_target;
          end
`ifdef CPU_FETCH_TIMEOUT_EN
          if (tmo_expired) begin
            mem_req_d  = 1'b0;
            ir_d       = INSTR_W'(INSTR_NOP);
            ir_valid_d = 1'b1;
            err_d      = 1'b1;
            pend_d     = 1'b0;
            state_d    = FS_DONE;
          end
`endif
        end
      end
      FS_DONE: begin
        if (branch_valid) pc_d = branch_target;
        state_d = FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FS_IDLE;
      pc_q        <= ADDR_W'(RESET_PC);
      mem_addr_q  <= '0;
      ir_q        <= '0;
      mem_req_q   <= 1'b0;
      ir_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
`ifdef CPU_FETCH_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      ir_q        <= ir_d;
      mem_req_q   <= mem_req_d;
      ir_valid_q  <= ir_valid_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
`ifdef CPU_FETCH_TIMEOUT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign ir         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign pc         = pc_q;
  assign fetch_done = (state_q == FS_DONE);
  assign busy       = (state_q != FS_IDLE);

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit: basic fetch, PC wrap, redirects, sleep, async reset and,
// when CPU_FETCH_TIMEOUT_EN is defined, the ack timeout.
module tb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start, branch_valid, sleep_req, mem_ack;
  logic [7:0]  branch_target;
  logic [15:0] mem_rdata;
  logic        mem_req, ir_valid, fetch_done, busy, fetch_err;
  logic [7:0]  mem_addr, pc;
  logic [15:0] ir;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_start   (fetch_start),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .sleep_req     (sleep_req),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .pc            (pc),
    .fetch_done    (fetch_done),
    .busy          (busy),
    .fetch_err     (fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch; ack after 'waits' extra REQ cycles; returns cycles from start to fetch_done.
  task automatic do_fetch(input string tag, input logic [7:0] exp_addr, input int waits,
                          input logic [15:0] data, output int latency);
    int n;
    fetch_start = 1'b1;
    tick();
    n = 1;
    fetch_start = 1'b0;
    check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'(exp_addr));
    repeat (waits) begin
      tick();
      n++;
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    while (n < 40) begin
      tick();
      n++;
      mem_ack = 1'b0;
      if (fetch_done) break;
    end
    latency = n + 1;
  endtask

  int lat;
  logic [7:0] pc_before;

  initial begin
    reset = 1'b0; fetch_start = 1'b0; branch_valid = 1'b0; branch_target = '0;
    sleep_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check("rst.pc", 32'(pc), 32'h00);
    check("rst.ir", 32'(ir), 32'h0000);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.flags", {29'd0, ir_valid, fetch_done, fetch_err}, 32'd0);
    reset = 1'b1;
    tick();

    // Basic fetch, ack in the first REQ cycle.
    do_fetch("basic", 8'h00, 0, 16'hA5C3, lat);
    check("basic.latency", 32'(lat), 32'd3);
    check("basic.done", 32'(fetch_done), 32'd1);
    check("basic.ir", 32'(ir), 32'hA5C3);
    check("basic.ir_valid", 32'(ir_valid), 32'd1);
    check("basic.pc", 32'(pc), 32'h01);
    check("basic.mem_req", 32'(mem_req), 32'd0);
    tick();
    check("basic.done_pulse", 32'(fetch_done), 32'd0);
    check("basic.idle", 32'(busy), 32'd0);

    // Branch in IDLE to 0xFF, then a 2-wait fetch wraps pc to 0.
    branch_valid = 1'b1; branch_target = 8'hFF;
    tick();
    branch_valid = 1'b0;
    check("wrap.pc_branch", 32'(pc), 32'hFF);
    do_fetch("wrap", 8'hFF, 2, 16'h1234, lat);
    check("wrap.latency", 32'(lat), 32'd5);
    check("wrap.pc", 32'(pc), 32'h00);
    check("wrap.ir", 32'(ir), 32'h1234);
    tick();

    // Redirect during REQ: first ack discarded, reissue at 0x40.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("redir.addr0", 32'(mem_addr), 32'h00);
    branch_valid = 1'b1; branch_target = 8'h40;
    tick();
    branch_valid = 1'b0;
    check("redir.addr_held", 32'(mem_addr), 32'h00);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    check("redir.no_done", 32'(fetch_done), 32'd0);
    check("redir.ir_kept", 32'(ir), 32'h1234);
    check("redir.req", 32'(mem_req), 32'd1);
    check("redir.addr1", 32'(mem_addr), 32'h40);
    tick();
    check("redir.wait_done", 32'(fetch_done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_ack = 1'b0;
    check("redir.done", 32'(fetch_done), 32'd1);
    check("redir.ir", 32'(ir), 32'h2222);
    check("redir.pc", 32'(pc), 32'h41);
    tick();
    check("redir.single_done", 32'(fetch_done), 32'd0);

    // Branch together with fetch_start in IDLE, then branch during DONE.
    branch_valid = 1'b1; branch_target = 8'h10; fetch_start = 1'b1;
    tick();
    branch_valid = 1'b0; fetch_start = 1'b0;
    check("brstart.addr", 32'(mem_addr), 32'h10);
    mem_ack = 1'b1; mem_rdata = 16'h0F0F;
    tick();
    mem_ack = 1'b0;
    check("brstart.pc", 32'(pc), 32'h11);
    check("brstart.done", 32'(fetch_done), 32'd1);
    branch_valid = 1'b1; branch_target = 8'h80;
    tick();
    branch_valid = 1'b0;
    check("brdone.pc", 32'(pc), 32'h80);

    // Sleep raised mid-REQ: fetch finishes, later starts ignored until sleep drops.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    sleep_req = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    check("sleep.done", 32'(fetch_done), 32'd1);
    check("sleep.ir", 32'(ir), 32'h5A5A);
    tick();
    for (int i = 0; i < 2; i++) begin
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      check("sleep.no_req", 32'(mem_req), 32'd0);
      check("sleep.no_busy", 32'(busy), 32'd0);
      tick();
    end
    check("sleep.ir_valid_kept", 32'(ir_valid), 32'd1);
    sleep_req = 1'b0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("wake.req", 32'(mem_req), 32'd1);
    check("wake.addr", 32'(mem_addr), 32'h81);
    check("wake.ir_valid_clr", 32'(ir_valid), 32'd0);

    // Async reset between edges while REQ is outstanding.
    #2 reset = 1'b0;
    #1;
    check("arst.mem_req", 32'(mem_req), 32'd0);
    check("arst.pc", 32'(pc), 32'h00);
    check("arst.busy", 32'(busy), 32'd0);
    #1 reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    check("arst.late_ack_ir", 32'(ir), 32'h0000);
    check("arst.late_ack_done", 32'(fetch_done), 32'd0);
    check("arst.late_ack_pc", 32'(pc), 32'h00);
    tick();

`ifdef CPU_FETCH_TIMEOUT_EN
    begin
      int req_cycles;
      pc_before = pc;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      req_cycles = 0;
      while (mem_req && req_cycles < 40) begin
        req_cycles++;
        tick();
      end
      check("tmo.req_cycles", 32'(req_cycles), 32'd15);
      check("tmo.done", 32'(fetch_done), 32'd1);
      check("tmo.ir_nop", 32'(ir), 32'h0000);
      check("tmo.err", 32'(fetch_err), 32'd1);
      check("tmo.pc", 32'(pc), 32'(pc_before));
      tick();
      check("tmo.err_sticky", 32'(fetch_err), 32'd1);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      check("tmo.err_clr", 32'(fetch_err), 32'd0);
      mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      tick();
      mem_ack = 1'b0;
      check("tmo.recover_ir", 32'(ir), 32'hBEEF);
      tick();
    end
`else
    pc_before = pc;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    repeat (30) tick();
    check("notmo.still_req", 32'(mem_req), 32'd1);
    check("notmo.err", 32'(fetch_err), 32'd0);
    check("notmo.pc", 32'(pc), 32'(pc_before));
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    check("notmo.ir", 32'(ir), 32'hBEEF);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
- Instruction fetch stage directly downstream of the CPU control FSM.
- When the FSM enters FETCH it pulses fetch_start. This block drives a single-outstanding req/ack read to program memory at the current PC, latches the returned word into the instruction register, advances the PC and returns fetch_done so the FSM can move to DECODE.
- Also handles branch redirects from the execute stage and sleep quiescing.

Parameters:
- ADDR_W, 8, program counter and memory address width.
- INSTR_W, 16, instruction word width.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, max cycles waiting for mem_ack (used only with the optional feature); must be at least 1.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_start  input  1  one-cycle pulse from the control FSM requesting a fetch.
- branch_valid  input  1  redirect PC this cycle.
- branch_target  input  ADDR_W  redirect address.
- sleep_req  input  1  finish any in-flight fetch, then refuse new starts.
- mem_req  output  1  memory read request.
- mem_addr  output  ADDR_W  read address; stable while mem_req=1.
- mem_ack  input  1  read data valid, one cycle.
- mem_rdata  input  INSTR_W  read data, sampled when mem_ack=1.
- ir  output  INSTR_W  instruction register.
- ir_valid  output  1  ir holds a fresh instruction; cleared on the next fetch_start.
- pc  output  ADDR_W  address of the next instruction to fetch.
- fetch_done  output  1  one-cycle pulse when ir is updated.
- busy  output  1  high in any state other than IDLE.
- fetch_err  output  1  timeout flag; sticky until the next fetch_start.

Behaviour:
- Reset (async, reset=0):
  - State IDLE; pc=RESET_PC; ir=0.
  - mem_req, ir_valid, fetch_done, fetch_err, busy all 0.
  - Pending-redirect flag cleared.
  - mem_req drops immediately even mid-transaction; a later mem_ack is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - fetch_start=1 and sleep_req=0 -> REQ.
  - In the same edge, mem_addr is loaded with pc and mem_req is set to 1.
  - fetch_start while sleep_req=1 is ignored (no transition, no pulse).
- REQ:
  - mem_req=1, mem_addr held constant.
  - On mem_ack=1 with no pending redirect:
    - ir<=mem_rdata, pc<=pc+1 (modulo 2^ADDR_W, so max wraps to 0).
    - mem_req<=0 -> DONE.
  - mem_ack in IDLE or DONE is ignored.
- DONE: fetch_done=1 and ir_valid=1 for exactly one cycle -> IDLE.
- Fetch latency: fetch_start to fetch_done is 2 + N cycles, where N is the cycles from mem_req rising to mem_ack (0 wait states gives 3).
- Branch in IDLE: pc<=branch_target. If fetch_start arrives in the same cycle, the request uses branch_target as its address, and pc becomes branch_target+1 on ack.
- Branch in REQ:
  - Target latched into the pending register.
  - On ack, data is discarded: ir unchanged, no fetch_done.
  - pc<=target; state re-enters REQ with mem_addr=target. The FSM sees only one completed fetch.
- Branch in DONE: pc<=branch_target, overriding the increment.
- sleep_req asserted mid-REQ: the current fetch completes normally.
- busy = (state != IDLE).

Optional Feature:
- Macro: CPU_FETCH_TIMEOUT_EN.
- Defined:
  - Counter clears on REQ entry and increments each REQ cycle without ack.
  - When it reaches TIMEOUT: mem_req<=0, ir<=0 (NOP), fetch_err<=1, pc unchanged -> DONE (fetch_done still pulses).
- Not defined: REQ waits indefinitely; fetch_err is tied to 0.

Decomposition:
- Package cpu_fetch_pkg holds:
  - state encodings FS_IDLE=2'b00, FS_REQ=2'b01, FS_DONE=2'b10;
  - INSTR_NOP constant;
  - default widths shared with the control FSM and decoder.
- One natural sub-module: fetch_timeout_counter (clear, enable, expired output). It is instantiated only under CPU_FETCH_TIMEOUT_EN.

Test Plan:
- Basic fetch: reset, pc=0; fetch_start, mem_ack one cycle after mem_req with rdata=16'hA5C3 -> mem_addr=0, ir=16'hA5C3, pc=1, fetch_done at cycle 3.
- Wrap: branch_valid with target 8'hFF in IDLE, then fetch with 2 wait states -> mem_addr=8'hFF, pc=8'h00 after ack, latency 5 cycles.
- Mid-fetch redirect: branch_target=8'h40 during REQ, ack with 16'h1111 -> 16'h1111 discarded, new request at 8'h40; ack 16'h2222 -> ir=16'h2222, pc=8'h41, exactly one fetch_done.
- Sleep: sleep_req during REQ -> fetch completes; subsequent fetch_start pulses produce no mem_req until sleep_req=0.
- Async reset mid-REQ: reset low between edges -> mem_req=0 immediately, pc=RESET_PC; a late mem_ack changes nothing.
- Timeout (macro defined, TIMEOUT=15): no ack -> after 15 REQ cycles mem_req=0, ir=0, fetch_err=1, fetch_done pulses, pc unchanged.
